link_rx_pkt_buffer: RTL and testbench

LINK_RX_PKT_BUFFER -- requirements
Module: link_rx_pkt_buffer

---
 rtl/link_rx_pkt_buffer.sv | 176 +++++++++++++++++
 tb/tb_link_rx_pkt_buffer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_rx_pkt_buffer.sv
// Store-and-forward ingress packet buffer: whole packets are committed before any beat is presented downstream.
// Optional dropped-packet counter is enabled with `define LINK_RX_DROP_CNT_EN.
module link_rx_pkt_buffer #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = 32,
  parameter int USER_WIDTH = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rx_pkt_valid,
  input  logic                  i_rx_pkt_start,
  input  logic                  i_rx_pkt_end,
  input  logic [USER_WIDTH-1:0] iv_rx_pkt_user,
  input  logic [KEEP_WIDTH-1:0] iv_rx_pkt_keep,
  input  logic [DATA_WIDTH-1:0] iv_rx_pkt_data,
  output logic                  o_rx_pkt_ready,
  output logic                  o_tx_pkt_valid,
  output logic                  o_tx_pkt_start,
  output logic                  o_tx_pkt_end,
  output logic [USER_WIDTH-1:0] ov_tx_pkt_user,
  output logic [KEEP_WIDTH-1:0] ov_tx_pkt_keep,
  output logic [DATA_WIDTH-1:0] ov_tx_pkt_data,
  input  logic                  i_tx_pkt_ready,
  output logic [31:0]           ov_drop_cnt
);

  localparam int AW    = DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int EW    = 2 + USER_WIDTH + KEEP_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_IN_PKT, S_DROP} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   fill;
  logic            full;
  logic            rx_acc;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   rd_entry;
  logic [EW-1:0]   mem_q [DEPTH];
  logic            avail;
  logic            load;
  logic            tx_vld_q, tx_start_q, tx_end_q;
  logic [USER_WIDTH-1:0] tx_user_q;
  logic [KEEP_WIDTH-1:0] tx_keep_q;
  logic [DATA_WIDTH-1:0] tx_data_q;

  // Fill level never exceeds DEPTH, so its MSB alone flags a full buffer.
  assign fill           = wr_ptr_q - rd_ptr_q;
  assign full           = fill[PW-1];
  assign o_rx_pkt_ready = rst & ((state_q == S_DROP) | ~full);
  assign rx_acc         = i_rx_pkt_valid & o_rx_pkt_ready;
  assign wr_entry       = {i_rx_pkt_start, i_rx_pkt_end, iv_rx_pkt_user, iv_rx_pkt_keep, iv_rx_pkt_data};

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_en        = 1'b0;
    wr_addr      = wr_ptr_q[AW-1:0];
    case (state_q)
      S_IDLE: begin
        if (rx_acc && i_rx_pkt_start) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (i_rx_pkt_end) commit_ptr_d = wr_ptr_q + 1'b1;
          else              state_d      = S_IN_PKT;
        end
      end
      S_IN_PKT: begin
        // An open packet that fills an otherwise empty buffer can never complete.
        if (full && (commit_ptr_q == rd_ptr_q)) begin
          wr_ptr_d = commit_ptr_q;
          state_d  = S_DROP;
        end else if (rx_acc) begin
          wr_en = 1'b1;
          if (i_rx_pkt_start) begin
            wr_addr  = commit_ptr_q[AW-1:0];
            wr_ptr_d = commit_ptr_q + 1'b1;
            if (i_rx_pkt_end) begin
              commit_ptr_d = commit_ptr_q + 1'b1;
              state_d      = S_IDLE;
            end
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (i_rx_pkt_end) begin
              commit_ptr_d = wr_ptr_q + 1'b1;
              state_d      = S_IDLE;
            end
          end
        end
      end
      S_DROP: begin
        if (rx_acc && i_rx_pkt_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_entry;
  end

  // Read side: only committed beats are moved into the registered output stage.
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
  assign avail    = (rd_ptr_q != commit_ptr_q);
  assign load     = avail & (~tx_vld_q | i_tx_pkt_ready);
  assign rd_ptr_d = load ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      tx_vld_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_end_q   <= 1'b0;
      tx_user_q  <= '0;
      tx_keep_q  <= '0;
      tx_data_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      if (load) begin
        tx_vld_q <= 1'b1;
        {tx_start_q, tx_end_q, tx_user_q, tx_keep_q, tx_data_q} <= rd_entry;
      end else if (i_tx_pkt_ready) begin
        tx_vld_q <= 1'b0;
      end
    end
  end

  assign o_tx_pkt_valid = tx_vld_q;
  assign o_tx_pkt_start = tx_start_q;
  assign o_tx_pkt_end   = tx_end_q;
  assign ov_tx_pkt_user = tx_user_q;
  assign ov_tx_pkt_keep = tx_keep_q;
  assign ov_tx_pkt_data = tx_data_q;

`ifdef LINK_RX_DROP_CNT_EN
  logic        drop_evt;
  logic [31:0] drop_cnt_q;

  assign drop_evt = (rx_acc & (state_q == S_IDLE)   & ~i_rx_pkt_start)
                  | (rx_acc & (state_q == S_IN_PKT) &  i_rx_pkt_start)
                  | ((state_q == S_IN_PKT) & full & (commit_ptr_q == rd_ptr_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else if (drop_evt && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign ov_drop_cnt = drop_cnt_q;
`else
  assign ov_drop_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_link_rx_pkt_buffer.sv
// Testbench for link_rx_pkt_buffer: table-driven packet cases plus hand-written corner sequences,
// with a beat scoreboard compared as the DUT presents output.
module tb_link_rx_pkt_buffer;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_valid = 1'b0, rx_start = 1'b0, rx_end = 1'b0;
  logic [UW-1:0] rx_user = '0;
  logic [KW-1:0] rx_keep = '0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_ready;
  logic          tx_valid, tx_start, tx_end;
  logic [UW-1:0] tx_user;
  logic [KW-1:0] tx_keep;
  logic [DW-1:0] tx_data;
  logic          tx_ready = 1'b0;
  logic [31:0]   drop_cnt;

  link_rx_pkt_buffer #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEPTH_LOG2(6)
  ) dut (
    .clk(clk), .rst(rst),
    .i_rx_pkt_valid(rx_valid), .i_rx_pkt_start(rx_start), .i_rx_pkt_end(rx_end),
    .iv_rx_pkt_user(rx_user), .iv_rx_pkt_keep(rx_keep), .iv_rx_pkt_data(rx_data),
    .o_rx_pkt_ready(rx_ready),
    .o_tx_pkt_valid(tx_valid), .o_tx_pkt_start(tx_start), .o_tx_pkt_end(tx_end),
    .ov_tx_pkt_user(tx_user), .ov_tx_pkt_keep(tx_keep), .ov_tx_pkt_data(tx_data),
    .i_tx_pkt_ready(tx_ready),
    .ov_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          s;
    logic          e;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    logic [DW-1:0] d;
  } beat_t;

  typedef struct {
    int len;
    int exp_lat;
    int exp_drop_inc;
  } case_t;

  beat_t        sb[$];
  int           n_pass = 0;
  int           n_total = 0;
  int           exp_drop = 0;
  bit           rand_bp = 1'b0;
  bit           stall_pend = 1'b0;
  logic [511:0] held;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [511:0] out_pack();
    return {189'd0, tx_valid, tx_start, tx_end, tx_user, tx_keep, tx_data};
  endfunction

  function automatic logic [511:0] beat_pack(input beat_t b);
    return {189'd0, 1'b1, b.s, b.e, b.u, b.k, b.d};
  endfunction

  function automatic int drop_model();
`ifdef LINK_RX_DROP_CNT_EN
    return exp_drop;
`else
    return 0;
`endif
  endfunction

  function automatic beat_t rnd_beat(input bit s, input bit e);
    beat_t b;
    b.s = s;
    b.e = e;
    b.u = $urandom();
    b.k = $urandom();
    for (int w = 0; w < DW / 32; w++) b.d[w*32 +: 32] = $urandom();
    return b;
  endfunction

  // One clock: check output hold/transfer against the scoreboard, then advance to the next falling edge.
  task automatic step();
    beat_t exp_b;
    if (stall_pend) chk("hold_stable", out_pack(), held);
    stall_pend = tx_valid && !tx_ready;
    held       = out_pack();
    if (tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", out_pack(), 512'd0);
      end else begin
        exp_b = sb.pop_front();
        chk("out_beat", out_pack(), beat_pack(exp_b));
      end
    end
    @(negedge clk);
    if (rand_bp) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_beat(input beat_t b);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    rx_valid = 1'b1;
    rx_start = b.s;
    rx_end   = b.e;
    rx_user  = b.u;
    rx_keep  = b.k;
    rx_data  = b.d;
    while (!ok && n < 300) begin
      ok = rx_ready;
      step();
      n++;
    end
    rx_valid = 1'b0;
    if (!ok) chk("rx_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_pkt(input int len, input bit push, input bit do_end);
    beat_t pk[$];
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b = rnd_beat(i == 0, do_end && (i == len - 1));
      send_beat(b);
      pk.push_back(b);
    end
    if (push) foreach (pk[i]) sb.push_back(pk[i]);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    case_t cases[5];
    int    lat;
    int    n;
    beat_t b17[$];
    beat_t b;

    cases[0] = '{len: 1, exp_lat: 2, exp_drop_inc: 0};
    cases[1] = '{len: 2, exp_lat: 2, exp_drop_inc: 0};
    cases[2] = '{len: 3, exp_lat: 2, exp_drop_inc: 0};
    cases[3] = '{len: 5, exp_lat: 2, exp_drop_inc: 0};
    cases[4] = '{len: 8, exp_lat: 2, exp_drop_inc: 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", rx_ready, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_beat", {tx_start, tx_end, tx_user, tx_keep, tx_data}, 512'd0);
    chk("rst_drop_cnt", drop_cnt, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_rst", rx_ready, 1'b1);

    // Table of well-formed packets: first-valid latency and unchanged drop count
    tx_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      send_pkt(cases[c].len, 1'b1, 1'b1);
      lat = 1;
      while (!tx_valid && lat < 10) begin
        step();
        lat++;
      end
      chk($sformatf("latency_len%0d", cases[c].len), lat, cases[c].exp_lat);
      drain(50);
      exp_drop += cases[c].exp_drop_inc;
      chk($sformatf("drop_len%0d", cases[c].len), drop_cnt, drop_model());
    end

    // Random downstream backpressure over several packets
    rand_bp = 1'b1;
    for (int p = 2; p <= 6; p++) send_pkt(p, 1'b1, 1'b1);
    drain(400);
    rand_bp  = 1'b0;
    tx_ready = 1'b1;
    step();

    // Beat without start in IDLE, then a 1-beat packet
    send_beat(rnd_beat(1'b0, 1'b0));
    exp_drop++;
    send_pkt(1, 1'b1, 1'b1);
    drain(20);
    chk("drop_nostart", drop_cnt, drop_model());

    // Missing end: restart on a new start beat
    send_pkt(2, 1'b0, 1'b0);
    send_pkt(2, 1'b1, 1'b1);
    exp_drop++;
    drain(20);
    chk("drop_restart", drop_cnt, drop_model());

    // Oversized packet with the output blocked
    tx_ready = 1'b0;
    send_pkt(70, 1'b0, 1'b1);
    exp_drop++;
    chk("oversize_rx_ready", rx_ready, 1'b1);
    chk("oversize_drop", drop_cnt, drop_model());
    repeat (4) step();
    chk("oversize_no_output", tx_valid, 1'b0);
    tx_ready = 1'b1;
    send_pkt(4, 1'b1, 1'b1);
    drain(20);
    chk("after_oversize_drop", drop_cnt, drop_model());
    step();

    // Fill to 64 stored beats behind a held output, stall, then drain at full rate
    tx_ready = 1'b0;
    for (int p = 0; p < 16; p++) send_pkt(4, 1'b1, 1'b1);
    b = rnd_beat(1'b1, 1'b0);
    send_beat(b);
    b17.push_back(b);
    chk("full_rx_ready", rx_ready, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stall_rx_ready", rx_ready, 1'b0);
    end
    tx_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain_cycles", n, 64);
    for (int i = 1; i < 4; i++) begin
      b = rnd_beat(1'b0, i == 3);
      send_beat(b);
      b17.push_back(b);
    end
    foreach (b17[i]) sb.push_back(b17[i]);
    drain(20);
    chk("full_seq_drop", drop_cnt, drop_model());
    step();

    // Reset in the middle of a packet with a committed packet still stored
    tx_ready = 1'b0;
    send_pkt(2, 1'b1, 1'b1);
    send_beat(rnd_beat(1'b1, 1'b0));
    rst = 1'b0;
    stall_pend = 1'b0;
    sb.delete();
    exp_drop = 0;
    #1;
    chk("midrst_rx_ready", rx_ready, 1'b0);
    chk("midrst_tx_valid", tx_valid, 1'b0);
    chk("midrst_drop", drop_cnt, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tx_ready = 1'b1;
    repeat (5) step();
    chk("postrst_tx_valid", tx_valid, 1'b0);
    chk("postrst_drop", drop_cnt, 32'd0);
    send_pkt(3, 1'b1, 1'b1);
    drain(20);
    repeat (3) step();
    chk("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
